fetch_sequencer: RTL and testbench

//  Controller for the instruction-fetch stage. Owns the PC and sequences a handshaked,

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_skid_buf.sv | 41 ++++
 rtl/fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_BLOCK = 2'd2,
        S_KILL  = 2'd3
    } fetch_state_e;

    localparam int          INST_W          = 32;
    localparam logic [31:0] PC_STEP         = 32'd4;
    localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_addr(input logic [31:0] addr);
        return addr & ADDR_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {inst, pc_plus} holding register for frozen decode
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic              flush_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic [31:0]       pc_plus_i,
    output logic              full_o,
    output logic [INST_W-1:0] inst_o,
    output logic [31:0]       pc_plus_o
);

    logic              full_q;
    logic [INST_W-1:0] inst_q;
    logic [31:0]       pc_plus_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 1'b0;
            inst_q    <= '0;
            pc_plus_q <= '0;
        end else if (flush_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q    <= 1'b1;
            inst_q    <= inst_i;
            pc_plus_q <= pc_plus_i;
        end else if (drain_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o    = full_q;
    assign inst_o    = inst_q;
    assign pc_plus_o = pc_plus_q;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and req/ack instruction-memory sequencer
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          WAIT_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [31:0]       branch_address,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [31:0]       if_pc_plus,
    output logic              fetch_err
);

    localparam int                CNT_W   = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WAIT_LIMIT);

    fetch_state_e      state_q;
    logic [31:0]       pc_q;
    logic [31:0]       tgt_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              fetch_err_q;
    logic              if_valid_q;
    logic [INST_W-1:0] if_inst_q;
    logic [31:0]       if_pc_plus_q;

    logic              req;
    logic              stall;
    logic              consume;
    logic              accept;
    logic              to_out;
    logic              to_skid;
    logic              skid_drain;
    logic              skid_full;
    logic [INST_W-1:0] skid_inst;
    logic [31:0]       skid_pc_plus;
    logic [31:0]       br_tgt;
    logic [31:0]       pc_next_seq;

    // In S_KILL pc_q still holds the abandoned address so mem_addr stays stable
    assign req         = (state_q == S_RUN) || (state_q == S_KILL);
    assign stall       = req && !mem_ack;
    assign consume     = if_valid_q && !freeze;
    assign accept      = (state_q == S_RUN) && mem_ack && !branch_taken;
    assign to_out      = accept && (!if_valid_q || consume);
    assign to_skid     = accept && !to_out;
    assign skid_drain  = (state_q == S_BLOCK) && consume && !branch_taken;
    assign br_tgt      = align_addr(branch_address);
    assign pc_next_seq = pc_q + PC_STEP;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst),
        .load_i    (to_skid),
        .drain_i   (skid_drain),
        .flush_i   (branch_taken),
        .inst_i    (mem_rdata),
        .pc_plus_i (pc_next_seq),
        .full_o    (skid_full),
        .inst_o    (skid_inst),
        .pc_plus_o (skid_pc_plus)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            tgt_q        <= RESET_PC;
            wait_cnt_q   <= '0;
            fetch_err_q  <= 1'b0;
            if_valid_q   <= 1'b0;
            if_inst_q    <= '0;
            if_pc_plus_q <= '0;
        end else begin
            if (!stall) begin
                wait_cnt_q <= '0;
            end else if (wait_cnt_q != CNT_MAX) begin
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            end
            if (wait_cnt_q == CNT_MAX) begin
                fetch_err_q <= 1'b1;
            end

            if (branch_taken) begin
                if_valid_q <= 1'b0;
                if (stall) begin
                    state_q <= S_KILL;
                    tgt_q   <= br_tgt;
                end else begin
                    state_q <= S_RUN;
                    pc_q    <= br_tgt;
                end
            end else begin
                if (to_out) begin
                    if_valid_q   <= 1'b1;
                    if_inst_q    <= mem_rdata;
                    if_pc_plus_q <= pc_next_seq;
                end else if (skid_drain && skid_full) begin
                    if_valid_q   <= 1'b1;
                    if_inst_q    <= skid_inst;
                    if_pc_plus_q <= skid_pc_plus;
                end else if (consume) begin
                    if_valid_q <= 1'b0;
                end

                case (state_q)
                    S_BOOT: state_q <= S_RUN;
                    S_RUN: begin
                        if (mem_ack) begin
                            pc_q <= pc_next_seq;
                            if (to_skid) begin
                                state_q <= S_BLOCK;
                            end
                        end
                    end
                    S_BLOCK: begin
                        if (skid_drain) begin
                            state_q <= S_RUN;
                        end
                    end
                    S_KILL: begin
                        if (mem_ack) begin
                            pc_q    <= tgt_q;
                            state_q <= S_RUN;
                        end
                    end
                    default: state_q <= S_BOOT;
                endcase
            end
        end
    end

    assign mem_req    = req;
    assign mem_addr   = pc_q;
    assign if_valid   = if_valid_q;
    assign if_inst    = if_inst_q;
    assign if_pc_plus = if_pc_plus_q;
    assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized bench for fetch_sequencer against a queue-level model
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          WAIT_LIMIT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc_plus;
    logic        fetch_err;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC   (RESET_PC),
        .WAIT_LIMIT (WAIT_LIMIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc_plus     (if_pc_plus),
        .fetch_err      (fetch_err)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pcp;
    } word_t;

    // Words owed to decode, oldest first: output register then skid
    word_t       q[$];
    logic        boot;
    logic        kill;
    logic [31:0] kill_addr;
    logic [31:0] exp_addr;
    logic        err_exp;
    int          run_len;
    int          lat_cnt;

    int          ack_mode;
    int          frz_mode;
    int          br_pct;
    logic        br_once;
    logic [31:0] br_tgt;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply_reset();
        rst            = 1'b0;
        freeze         = 1'b0;
        branch_taken   = 1'b0;
        branch_address = '0;
        mem_ack        = 1'b0;
        mem_rdata      = '0;
        q.delete();
        boot     = 1'b1;
        kill     = 1'b0;
        exp_addr = RESET_PC;
        err_exp  = 1'b0;
        run_len  = 0;
        lat_cnt  = 0;
        br_once  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_inst", if_inst, 32'd0);
        check("rst_if_pc_plus", if_pc_plus, 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        rst = 1'b1;
    endtask

    // One cycle, entered and left at a falling edge
    task automatic step();
        logic        req, val, err, frz, br, ack;
        logic [31:0] addr, inst, pcp, bra, rd;
        word_t       w;
        req  = mem_req;
        addr = mem_addr;
        val  = if_valid;
        inst = if_inst;
        pcp  = if_pc_plus;
        err  = fetch_err;

        check("if_valid", 32'(val), 32'(q.size() > 0));
        if (val && q.size() > 0) begin
            check("if_inst", inst, q[0].inst);
            check("if_pc_plus", pcp, q[0].pcp);
        end
        check("mem_req", 32'(req), 32'(!boot && q.size() < 2));
        if (req) check("mem_addr", addr, kill ? kill_addr : exp_addr);
        check("fetch_err", 32'(err), 32'(err_exp));

        case (frz_mode)
            0:       frz = 1'b0;
            1:       frz = 1'b1;
            default: frz = ($urandom_range(0, 99) < 30);
        endcase
        br  = br_once || ($urandom_range(0, 99) < br_pct);
        bra = br_once ? br_tgt : $urandom;
        br_once = 1'b0;
        case (ack_mode)
            0:       ack = req;
            1:       ack = req && (lat_cnt == 2);
            2:       ack = 1'b0;
            default: ack = req && ($urandom_range(0, 1) == 1);
        endcase
        lat_cnt = (req && !ack) ? lat_cnt + 1 : 0;
        rd = ack ? mem_word(addr) : $urandom;

        freeze         = frz;
        branch_taken   = br;
        branch_address = bra;
        mem_ack        = ack;
        mem_rdata      = rd;

        if (run_len >= WAIT_LIMIT) err_exp = 1'b1;
        run_len = (req && !ack) ? run_len + 1 : 0;

        if (br) begin
            q.delete();
            if (req && !ack) begin
                if (!kill) kill_addr = addr;
                kill = 1'b1;
            end else begin
                kill = 1'b0;
            end
            exp_addr = bra & 32'hFFFF_FFFC;
        end else begin
            if (val && !frz && q.size() > 0) void'(q.pop_front());
            if (req && ack) begin
                if (kill) begin
                    kill = 1'b0;
                end else begin
                    w.inst = rd;
                    w.pcp  = addr + 32'd4;
                    q.push_back(w);
                    exp_addr = addr + 32'd4;
                end
            end
        end
        boot = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int guard;
        ack_mode = 0;
        frz_mode = 0;
        br_pct   = 0;
        br_tgt   = '0;
        @(negedge clk);

        apply_reset();
        repeat (20) step();
        ack_mode = 1;
        repeat (30) step();

        ack_mode = 0;
        repeat (3) step();
        frz_mode = 1;
        repeat (5) step();
        frz_mode = 0;
        repeat (6) step();

        for (int f = 0; f < 2; f++) begin
            apply_reset();
            ack_mode = 1;
            frz_mode = 0;
            guard = 0;
            while (!(mem_req === 1'b1 && mem_addr == 32'h8 && lat_cnt == 0) && guard < 100) begin
                step();
                guard++;
            end
            check("reach_req_0x8", 32'(guard < 100), 32'd1);
            frz_mode = f;
            br_once  = 1'b1;
            br_tgt   = 32'h100;
            step();
            check("kill_addr_held", mem_addr, 32'h8);
            repeat (12) step();
            frz_mode = 0;
            repeat (6) step();
        end

        apply_reset();
        ack_mode = 3;
        frz_mode = 2;
        br_pct   = 4;
        repeat (600) step();

        apply_reset();
        ack_mode = 2;
        frz_mode = 0;
        br_pct   = 0;
        repeat (WAIT_LIMIT + 6) step();
        check("fetch_err_set", 32'(fetch_err), 32'd1);
        ack_mode = 0;
        repeat (5) step();
        check("fetch_err_sticky", 32'(fetch_err), 32'd1);

        apply_reset();
        guard = 0;
        while (!(mem_req === 1'b1 && mem_addr == 32'h40) && guard < 200) begin
            step();
            guard++;
        end
        check("reach_req_0x40", 32'(guard < 200), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_async_req", 32'(mem_req), 32'd0);
        apply_reset();
        repeat (2) step();
        check("restart_addr", mem_addr, RESET_PC + 32'd4);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
